// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller:
// opcodes, funct codes, ALU selects, mux encodings and FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_NOP  = 6'b000000;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_SLLV = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef logic [3:0] state_t;

    localparam state_t S_RESET   = 4'd0;
    localparam state_t S_FETCH   = 4'd1;
    localparam state_t S_DECODE  = 4'd2;
    localparam state_t S_MEMADR  = 4'd3;
    localparam state_t S_MEMRD   = 4'd4;
    localparam state_t S_MEMWB   = 4'd5;
    localparam state_t S_MEMWR   = 4'd6;
    localparam state_t S_EXECUTE = 4'd7;
    localparam state_t S_ALUWB   = 4'd8;
    localparam state_t S_BRANCH  = 4'd9;
    localparam state_t S_ADDIEX  = 4'd10;
    localparam state_t S_ADDIWB  = 4'd11;
    localparam state_t S_JUMP    = 4'd12;

endpackage

// File: rtl/alu_func_decoder.sv
// R-type funct field to ALU operation; flags funct codes
// the datapath does not implement.
module alu_func_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_func,
    output logic [3:0] o_alu_sel,
    output logic       o_func_illegal
);

    always_comb begin
        o_alu_sel      = ALU_ADD;
        o_func_illegal = 1'b0;
        case (i_func)
            FN_ADD:  o_alu_sel = ALU_ADD;
            FN_SUB:  o_alu_sel = ALU_SUB;
            FN_AND:  o_alu_sel = ALU_AND;
            FN_OR:   o_alu_sel = ALU_OR;
            FN_SLT:  o_alu_sel = ALU_SLT;
            FN_SLLV: o_alu_sel = ALU_SLLV;
            FN_NOP:  o_alu_sel = ALU_SLLV;
            default: o_func_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencing FSM for the multicycle MIPS datapath; FETCH
// enables and MEMWR completion follow mem_ready directly.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_re,
    output logic       mem_we,
    output logic       rf_we,
    output logic       rf_dsel,
    output logic       mtorf_sel,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [1:0] pc_src,
    output logic [3:0] alu_sel,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic       r_illegal;
    logic       w_set_ill;
    logic       w_op_ill;
    logic [3:0] w_fn_alu;
    logic       w_fn_ill;

    alu_func_decoder u_fdec (
        .i_func         (func),
        .o_alu_sel      (w_fn_alu),
        .o_func_illegal (w_fn_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_ill)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_op_ill = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_RTYPE,
            OP_BEQ, OP_ADDI, OP_J: w_op_ill = 1'b0;
            default:               w_op_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_set_ill = 1'b0;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_EXECUTE: begin
                w_next    = S_ALUWB;
                w_set_ill = w_fn_ill;
            end
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH,
            S_ADDIWB, S_JUMP: w_next = S_FETCH;
            default:  w_next = S_RESET;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        rf_we      = 1'b0;
        rf_dsel    = 1'b0;
        mtorf_sel  = 1'b0;
        alu_srca   = 1'b0;
        alu_srcb   = SRCB_REGB;
        pc_src     = PCSRC_ALU;
        alu_sel    = ALU_ADD;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_re   = 1'b1;
                alu_srcb = SRCB_FOUR;
                ir_we    = mem_ready;
                pc_we    = mem_ready;
            end
            S_DECODE: begin
                alu_srcb   = SRCB_IMMSH;
                instr_done = w_op_ill;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_srca = 1'b1;
                alu_srcb = SRCB_IMM;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                mem_re = 1'b1;
            end
            S_MEMWB: begin
                rf_we      = 1'b1;
                mtorf_sel  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTE: begin
                alu_srca = 1'b1;
                alu_sel  = w_fn_alu;
            end
            S_ALUWB: begin
                rf_dsel    = 1'b1;
                rf_we      = ~w_fn_ill;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_srca   = 1'b1;
                alu_sel    = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_we      = zero;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_we      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected
// output vectors are queued with stimulus and compared per scenario.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       pc_we, ir_we, iord, mem_re, mem_we, rf_we;
    logic       rf_dsel, mtorf_sel, alu_srca;
    logic [1:0] alu_srcb, pc_src;
    logic [3:0] alu_sel;
    logic       instr_done, illegal;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .func       (func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .iord       (iord),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .rf_we      (rf_we),
        .rf_dsel    (rf_dsel),
        .mtorf_sel  (mtorf_sel),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .pc_src     (pc_src),
        .alu_sel    (alu_sel),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_re;
        logic       mem_we;
        logic       rf_we;
        logic       rf_dsel;
        logic       mtorf_sel;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [1:0] pc_src;
        logic [3:0] alu_sel;
        logic       instr_done;
        logic       illegal;
    } ov_t;

    typedef enum {
        T_RESET, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB,
        T_MEMWR, T_EXEC, T_ALUWB, T_BRANCH, T_ADDIEX, T_ADDIWB, T_JUMP
    } tst_e;

    ov_t exp_q[$];
    ov_t obs_q[$];
    int  n_checks = 0;
    int  n_err    = 0;
    bit  exp_ill  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Expected outputs of one state; flag = illegal op in DECODE, rf_we in ALUWB.
    function automatic ov_t ev(tst_e s, bit mr, bit z,
                               logic [3:0] alu, bit flag);
        ov_t v;
        v = '0;
        v.alu_sel = 4'b0010;
        v.illegal = exp_ill;
        case (s)
            T_RESET:  v.illegal = 1'b0;
            T_FETCH: begin
                v.mem_re = 1; v.alu_srcb = 2'b01;
                v.ir_we = mr; v.pc_we = mr;
            end
            T_DECODE: begin v.alu_srcb = 2'b11; v.instr_done = flag; end
            T_MEMADR, T_ADDIEX: begin v.alu_srca = 1; v.alu_srcb = 2'b10; end
            T_MEMRD:  begin v.iord = 1; v.mem_re = 1; end
            T_MEMWB:  begin v.rf_we = 1; v.mtorf_sel = 1; v.instr_done = 1; end
            T_MEMWR:  begin v.iord = 1; v.mem_we = 1; v.instr_done = mr; end
            T_EXEC:   begin v.alu_srca = 1; v.alu_sel = alu; end
            T_ALUWB:  begin v.rf_dsel = 1; v.rf_we = flag; v.instr_done = 1; end
            T_BRANCH: begin
                v.alu_srca = 1; v.alu_sel = 4'b0011; v.pc_src = 2'b01;
                v.pc_we = z; v.instr_done = 1;
            end
            T_ADDIWB: begin v.rf_we = 1; v.instr_done = 1; end
            T_JUMP:   begin v.pc_src = 2'b10; v.pc_we = 1; v.instr_done = 1; end
            default: ;
        endcase
        return v;
    endfunction

    function automatic ov_t cur();
        ov_t v;
        v = {pc_we, ir_we, iord, mem_re, mem_we, rf_we, rf_dsel, mtorf_sel,
             alu_srca, alu_srcb, pc_src, alu_sel, instr_done, illegal};
        return v;
    endfunction

    task automatic step(input bit mr, input bit z, input bit r, input ov_t e);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        rst       = r;
        #1;
        exp_q.push_back(e);
        obs_q.push_back(cur());
    endtask

    task automatic test_reset();
        ov_t e, o;
        int  k = 0;
        step(0, 0, 1, ev(T_RESET, 0, 0, 0, 0));
        step(0, 0, 1, ev(T_RESET, 0, 0, 0, 0));
        step(0, 0, 0, ev(T_RESET, 0, 0, 0, 0));
        step(0, 0, 0, ev(T_FETCH, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_lw();
        ov_t e, o;
        int  k = 0;
        op = 6'b100011;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_MEMADR, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_MEMRD, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_MEMWB, 1, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL lw c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_sw_wait();
        ov_t e, o;
        int  k = 0;
        op = 6'b101011;
        step(0, 0, 0, ev(T_FETCH, 0, 0, 0, 0));
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(0, 0, 0, ev(T_DECODE, 0, 0, 0, 0));
        step(0, 0, 0, ev(T_MEMADR, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, ev(T_MEMWR, 0, 0, 0, 0));
        step(1, 0, 0, ev(T_MEMWR, 1, 0, 0, 0));
        step(0, 0, 0, ev(T_FETCH, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sw_wait c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_beq();
        ov_t e, o;
        int  k = 0;
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
            step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
            step(1, z[0], 0, ev(T_BRANCH, 1, z[0], 0, 0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL beq c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_rtype();
        ov_t        e, o;
        int         k = 0;
        logic [5:0] fn [7];
        logic [3:0] al [7];
        fn = '{6'b100010, 6'b100000, 6'b100100, 6'b100101,
               6'b101010, 6'b000100, 6'b000000};
        al = '{4'b0011, 4'b0010, 4'b0000, 4'b0001,
               4'b1010, 4'b1001, 4'b1001};
        op = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            func = fn[i];
            step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
            step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
            step(1, 0, 0, ev(T_EXEC, 1, 0, al[i], 0));
            step(1, 0, 0, ev(T_ALUWB, 1, 0, 0, 1));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rtype c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        ov_t e, o;
        int  k = 0;
        op = 6'b001000;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_ADDIEX, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_ADDIWB, 1, 0, 0, 0));
        op = 6'b000010;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_JUMP, 1, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL back_to_back c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_illegal_func();
        ov_t e, o;
        int  k = 0;
        op   = 6'b000000;
        func = 6'b111111;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_EXEC, 1, 0, 4'b0010, 0));
        exp_ill = 1;
        step(1, 0, 0, ev(T_ALUWB, 1, 0, 0, 0));
        op = 6'b000010;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_JUMP, 1, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL illegal_func c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_rst_abort();
        ov_t e, o;
        int  k = 0;
        op = 6'b100011;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 0));
        step(0, 0, 0, ev(T_MEMADR, 0, 0, 0, 0));
        step(0, 0, 0, ev(T_MEMRD, 0, 0, 0, 0));
        step(1, 0, 1, ev(T_MEMRD, 1, 0, 0, 0));
        exp_ill = 0;
        step(1, 0, 0, ev(T_RESET, 1, 0, 0, 0));
        step(0, 0, 0, ev(T_FETCH, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL rst_abort c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    task automatic test_illegal_op();
        ov_t e, o;
        int  k = 0;
        op = 6'b111111;
        step(1, 0, 0, ev(T_FETCH, 1, 0, 0, 0));
        step(1, 0, 0, ev(T_DECODE, 1, 0, 0, 1));
        exp_ill = 1;
        step(0, 0, 0, ev(T_FETCH, 0, 0, 0, 0));
        step(0, 0, 0, ev(T_FETCH, 0, 0, 0, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_err++;
                $display("FAIL illegal_op c%0d: got %h required %h", k, o, e);
            end
            k++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        op        = 6'b000000;
        func      = 6'b100000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_rtype();
        test_back_to_back();
        test_illegal_func();
        test_rst_abort();
        test_illegal_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
